// File: rtl/mxbus_pkg.sv
// Shared types and constants for the MX Bus master bus-interface unit.
package mxbus_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CPL, RESP} biu_state_t;

  localparam int MXBUS_DATA_W          = 8;
  localparam int MXBUS_DEFAULT_TIMEOUT = 16;

  // Response payload held for the core while in RESP.
  typedef struct packed {
    logic [MXBUS_DATA_W-1:0] rdata;
    logic                    err;
  } biu_rsp_t;

endpackage

// File: rtl/mxbus_master_biu_wdog.sv
// Transaction watchdog: counts cycles while enabled and flags the last allowed cycle.
module mxbus_txn_wdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // The FSM leaves ISSUE/WAIT_CPL on this cycle, so cnt never wraps.
  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mxbus_master_biu.sv
// Single-outstanding MX Bus master: core valid/ready request in, one MX Bus
// read or write transaction out, response (data or timeout error) back.
module mxbus_master_biu
  import mxbus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = MXBUS_DATA_W,
  parameter int TIMEOUT_CYCLES = MXBUS_DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  m0_wr_txn_start,
  output logic [DATA_WIDTH-1:0] m0_wr_data,
  output logic [ADDR_WIDTH-1:0] m0_wr_addr,
  input  logic                  m0_wr_ready,
  input  logic                  m0_wr_txn_ack,
  input  logic                  m0_wr_txn_cpl,
  output logic                  m0_rd_txn_start,
  output logic [ADDR_WIDTH-1:0] m0_rd_addr,
  input  logic [DATA_WIDTH-1:0] m0_rd_data,
  input  logic                  m0_rd_ready,
  input  logic                  m0_rd_txn_ack,
  input  logic                  m0_rd_txn_cpl
);

  biu_state_t state, state_nxt;
  biu_rsp_t   rsp_q, rsp_nxt, done_rsp;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept, start, expired;
  logic                  sel_ack, sel_cpl;

  assign sel_ack = we_q ? m0_wr_txn_ack : m0_rd_txn_ack;
  assign sel_cpl = we_q ? m0_wr_txn_cpl : m0_rd_txn_cpl;

  mxbus_txn_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      ((state == ISSUE) || (state == WAIT_CPL)),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rsp_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      rsp_q <= rsp_nxt;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    rsp_nxt        = rsp_q;
    req_ready      = 1'b0;
    accept         = 1'b0;
    start          = 1'b0;
    done_rsp.err   = 1'b0;
    done_rsp.rdata = we_q ? '0 : MXBUS_DATA_W'(m0_rd_data);
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        start = we_q ? m0_wr_ready : m0_rd_ready;
        // cpl alone counts as ack+cpl; completion beats an expiring watchdog,
        // but a bare ack on the last cycle does not extend the budget.
        if (sel_cpl) begin
          state_nxt = RESP;
          rsp_nxt   = done_rsp;
        end else if (expired) begin
          state_nxt = RESP;
          rsp_nxt   = '{rdata: '0, err: 1'b1};
        end else if (sel_ack && start) begin
          state_nxt = WAIT_CPL;
        end
      end
      WAIT_CPL: begin
        if (sel_cpl) begin
          state_nxt = RESP;
          rsp_nxt   = done_rsp;
        end else if (expired) begin
          state_nxt = RESP;
          rsp_nxt   = '{rdata: '0, err: 1'b1};
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid       = (state == RESP);
  assign rsp_rdata       = DATA_WIDTH'(rsp_q.rdata);
  assign rsp_err         = rsp_q.err;
  assign m0_wr_txn_start = start & we_q;
  assign m0_rd_txn_start = start & ~we_q;
  assign m0_wr_addr      = addr_q;
  assign m0_wr_data      = wdata_q;
  assign m0_rd_addr      = addr_q;

endmodule

// File: tb/tb_mxbus_master_biu.sv
// Scoreboard bench for mxbus_master_biu with ROM/RAM slave models on both ports.
module tb_mxbus_master_biu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       m0_wr_txn_start, m0_wr_ready, m0_wr_txn_ack, m0_wr_txn_cpl;
  logic [7:0] m0_wr_data, m0_wr_addr;
  logic       m0_rd_txn_start, m0_rd_ready, m0_rd_txn_ack, m0_rd_txn_cpl;
  logic [7:0] m0_rd_addr, m0_rd_data;

  always #5 clk = ~clk;

  mxbus_master_biu #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m0_wr_txn_start(m0_wr_txn_start), .m0_wr_data(m0_wr_data), .m0_wr_addr(m0_wr_addr),
    .m0_wr_ready(m0_wr_ready), .m0_wr_txn_ack(m0_wr_txn_ack), .m0_wr_txn_cpl(m0_wr_txn_cpl),
    .m0_rd_txn_start(m0_rd_txn_start), .m0_rd_addr(m0_rd_addr), .m0_rd_data(m0_rd_data),
    .m0_rd_ready(m0_rd_ready), .m0_rd_txn_ack(m0_rd_txn_ack), .m0_rd_txn_cpl(m0_rd_txn_cpl)
  );

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave models. rmode: 0 zero-wait ROM, 1 registered (cpl rdly cycles after ack), 2 never ready.
  logic [7:0] mem [256];
  int         rmode = 0, rdly = 0, rcnt = 0;
  logic       rack = 1'b0, rcpl = 1'b0, rpend = 1'b0, wack = 1'b0, wcpl = 1'b0;
  logic [7:0] rdat = '0;

  assign m0_rd_ready   = (rmode != 2);
  assign m0_rd_txn_ack = (rmode == 0) ? m0_rd_txn_start : rack;
  assign m0_rd_txn_cpl = (rmode == 0) ? m0_rd_txn_start : rcpl;
  assign m0_rd_data    = (rmode == 0) ? mem[m0_rd_addr] : (rcpl ? rdat : 8'hEE);
  assign m0_wr_ready   = 1'b1;
  assign m0_wr_txn_ack = wack;
  assign m0_wr_txn_cpl = wcpl;

  always @(posedge clk) begin
    rack <= 1'b0;
    rcpl <= 1'b0;
    if (rpend) begin
      if (rcnt <= 1) begin
        rcpl  <= 1'b1;
        rdat  <= mem[m0_rd_addr];
        rpend <= 1'b0;
      end else rcnt <= rcnt - 1;
    end else if (rmode == 1 && m0_rd_txn_start && !rack) begin
      rack <= 1'b1;
      if (rdly == 0) begin
        rcpl <= 1'b1;
        rdat <= mem[m0_rd_addr];
      end else begin
        rpend <= 1'b1;
        rcnt  <= rdly;
      end
    end
  end

  always @(posedge clk) begin
    wack <= 1'b0;
    wcpl <= 1'b0;
    if (rst) mem[8'h10] <= 8'hA5;
    else if (m0_wr_txn_start && !wack) begin
      wack <= 1'b1;
      wcpl <= 1'b1;
      mem[m0_wr_addr] <= m0_wr_data;
    end
  end

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
    int         rdn;
    int         wrn;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: latency from accept cycle to rsp_valid rise, start-cycle counts,
  // and response contents popped from the scoreboard at each handshake.
  int   acc_cyc = 0, lat_meas = 0, rd_n = 0, wr_n = 0;
  logic vprev = 1'b0;
  exp_t e;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (req_valid && req_ready) begin
        acc_cyc = cyc;
        rd_n    = 0;
        wr_n    = 0;
      end
      if (m0_rd_txn_start) rd_n++;
      if (m0_wr_txn_start) wr_n++;
      if (rsp_valid && !vprev) begin
        lat_meas = cyc - acc_cyc;
        chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_latency", 32'(lat_meas), 32'(e.lat));
        chk("rd_start_cycles", 32'(rd_n), 32'(e.rdn));
        chk("wr_start_cycles", 32'(wr_n), 32'(e.wrn));
      end
      vprev = rsp_valid;
    end
  end

  // Call at #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    int n;
    n         = 0;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!(req_ready && sb.size() == 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL done_timeout: got %0d pending responses expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_starts", 32'({m0_rd_txn_start, m0_wr_txn_start}), 32'd0);
    @(posedge clk); #1;

    // Zero-wait ROM read.
    rmode = 0;
    sb.push_back('{8'hA5, 1'b0, 2, 1, 0});
    send(1'b0, 8'h10, 8'h00);
    wait_done();

    // Registered RAM write then read back.
    rmode = 1; rdly = 0;
    sb.push_back('{8'h00, 1'b0, 3, 0, 2});
    send(1'b1, 8'h22, 8'h3C);
    wait_done();
    sb.push_back('{8'h3C, 1'b0, 3, 2, 0});
    send(1'b0, 8'h22, 8'h00);
    wait_done();

    // Unready slave: watchdog error after 16 cycles in ISSUE.
    rmode = 2;
    sb.push_back('{8'h00, 1'b1, 17, 0, 0});
    send(1'b0, 8'h30, 8'h00);
    wait_done();

    // Response back-pressure with a second request waiting.
    rmode = 0;
    rsp_ready = 1'b0;
    sb.push_back('{8'hA5, 1'b0, 2, 1, 0});
    send(1'b0, 8'h10, 8'h00);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_rsp_seen", 32'(rsp_valid), 32'd1);
    sb.push_back('{8'hA5, 1'b0, 2, 1, 0});
    @(posedge clk); #1;
    req_we = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", 32'(rsp_rdata), 32'hA5);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_handshake_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("hold_next_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done();

    // Ack then cpl three cycles later; data bus is junk outside the cpl cycle.
    rmode = 1; rdly = 3;
    sb.push_back('{8'hA5, 1'b0, 6, 2, 0});
    send(1'b0, 8'h10, 8'h00);
    wait_done();
    repeat (3) @(posedge clk); #1;

    // Reset while in WAIT_CPL: no response, late cpl ignored.
    send(1'b0, 8'h10, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_starts", 32'({m0_rd_txn_start, m0_wr_txn_start}), 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_still_idle", 32'({req_ready, rsp_valid}), 32'b10);
    @(posedge clk); #1;

    // Recovery: RAM still holds 0x3C at 0x22.
    rmode = 0;
    sb.push_back('{8'h3C, 1'b0, 2, 1, 0});
    send(1'b0, 8'h22, 8'h00);
    wait_done();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
